des_iter_core: RTL and testbench
================================

// Module: des_iter_core
// PURPOSE
// - Iterative DES block engine: 1 Feistel round per clock, 16 rounds per 64-bit block.
// - Wraps the eight S-box stages (S_Box_1..S_Box_8) and supplies the rest of the datapath:
//   - upstream: E expansion and subkey XOR, feeding the S-boxes;
//   - downstream: P permutation and L/R swap, consuming the S-box outputs.
// - Contains IP, FP and the on-the-fly key schedule (PC-1, per-round rotates, PC-2).
// - Sits between the stream packer and the ciphertext FIFO.
// PARAMETERS
// - none. Widths are fixed by DES.
// PORTS
// clk        in   1   rising-edge clock, single clock domain
// rst        in   1   synchronous reset, active-high
// in_valid   in   1   block+key offered
// in_ready   out  1   core can accept a block
// in_block   in   64  plaintext/ciphertext, bit 63 = DES bit 1
// in_key     in   64  key incl. parity bits (parity ignored)
// out_valid  out  1   result available
// out_ready  in   1   consumer accepts result
// out_block  out  64  result, bit 63 = DES bit 1
// BEHAVIOUR
// - Reset values: in_ready=0 during rst, then 1. out_valid=0, out_block=0. State=IDLE, round counter=0.
// - FSM IDLE -> ROUND -> DONE -> IDLE.
//   - IDLE: in_ready=1. A transfer happens when in_valid&in_ready. On that edge:
//     - L,R <= IP(in_block);
//     - C,D <= PC1(in_key);
//     - rnd <= 1;
//     - state goes to ROUND.
//   - ROUND, each cycle:
//     - rotate C,D: shift 1 in rounds 1,2,9,16, else shift 2;
//     - K = PC2(rotated C,D);
//     - f = P(Sboxes(E(R)^K));
//     - L <= R, R <= L^f;
//     - rnd increments.
//   - After round 16 the swap is undone. out_block <= FP(R16,L16), out_valid <= 1, state goes to DONE.
//   - DONE: out_valid=1 and out_block is held stable until out_ready.
//     - On out_valid&out_ready: out_valid <= 0 and state goes to IDLE.
//     - The next input can be accepted no earlier than the following cycle.
// - Latency: input accepted at edge N -> out_valid high after edge N+16. Throughput 1 block / 18 cycles with out_ready held high.
// - in_ready=0 in ROUND and DONE. in_valid is ignored there, and in_block/in_key are not sampled.
// - S-box index rule: 6-bit input {b1..b6}. Row = {b1,b6}, column = b2..b5. The S-boxes are combinational, so there is no extra latency.
// - Reset mid-operation: the round in progress is aborted and nothing is output. All state returns to reset values on the next edge.
// - out_ready held high in IDLE/ROUND has no effect. in_valid and out_ready arriving together in DONE: only the output handshake completes.
// - Key parity bits are never checked. Weak keys are processed without any flag.
// CONFIGURATION
// - Macro DES_DECRYPT_EN.
// - Defined:
//   - adds input port in_decrypt (1 bit), sampled with in_block;
//   - when in_decrypt=1 the subkeys are applied K16..K1: C,D rotate right, with shift 0 in round 1, shift 1 in rounds 2,9,16, else shift 2;
//   - the mode is latched per block and does not affect latency.
// - Undefined: the port is absent and the core is encrypt-only. Logic is identical to in_decrypt tied to 0.
// TESTING
// - Encrypt key=133457799BBCDFF1, in=0123456789ABCDEF -> out=85E813540F0AB405, out_valid exactly 16 cycles after accept.
// - Encrypt key=0E329232EA6D0D73, in=8787878787878787 -> out=0000000000000000.
// - Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_block stable, in_ready=0 throughout; release -> one transfer, in_ready=1 on the next cycle.
// - Reset mid-op: assert rst at round 7 -> out_valid never rises. The next block (first vector) still gives 85E813540F0AB405.
// - DES_DECRYPT_EN: in_decrypt=1, key=133457799BBCDFF1, in=85E813540F0AB405 -> out=0123456789ABCDEF.
// - Back-to-back: 4 random blocks with in_valid and out_ready held high -> results match the software model, one accept every 18 cycles.

Source files
------------

// File: rtl/des_iter_if.sv
// Block/key in, result out handshake bundle for des_iter_core.
// With DES_DECRYPT_EN defined, in_decrypt travels alongside in_block.
interface des_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic [63:0] in_key;
`ifdef DES_DECRYPT_EN
    logic        in_decrypt;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;

`ifdef DES_DECRYPT_EN
    modport master (
        output in_valid, in_block, in_key, in_decrypt, out_ready,
        input  in_ready, out_valid, out_block
    );
    modport slave (
        input  in_valid, in_block, in_key, in_decrypt, out_ready,
        output in_ready, out_valid, out_block
    );
`else
    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );
    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );
`endif
endinterface

// File: rtl/des_iter_core.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds per block, on-the-fly key schedule.
// Optional DES_DECRYPT_EN adds a per-block in_decrypt select (subkeys applied K16..K1).
module des_iter_core (
    input  logic      clk,
    input  logic      rst,
    des_iter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    // Tables use DES 1-based bit numbering; bit 1 is the MSB of each vector.
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
    };
    localparam int E_TAB [48] = '{
        32, 1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1
    };
    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17,  1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,   19, 13, 30, 6,  22, 11, 4,  25
    };
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17, 9,   1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27,  19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29,  21, 13, 5,  28, 20, 12, 4
    };
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24, 1,  5,   3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,   16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };
    // S_Box_1..S_Box_8, four rows each; column 0 is the leading nibble of every row.
    localparam logic [63:0] SBOX_ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63 - i] = x[64 - IP_TAB[i]];
        return r;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63 - i] = x[64 - FP_TAB[i]];
        return r;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47 - i] = x[32 - E_TAB[i]];
        return r;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31 - i] = x[32 - P_TAB[i]];
        return r;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55 - i] = x[64 - PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47 - i] = x[56 - PC2_TAB[i]];
        return r;
    endfunction

    // Row = {b1,b6}, column = b2..b5.
    function automatic logic [3:0] sbox(input int idx, input logic [5:0] x);
        logic [63:0] row;
        int          col;
        row = SBOX_ROWS[idx * 4 + int'({x[5], x[0]})];
        col = int'(x[4:1]);
        return row[(15 - col) * 4 +: 4];
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = e_expand(r) ^ k;
        for (int i = 0; i < 8; i++) s[31 - 4 * i -: 4] = sbox(i, x[47 - 6 * i -: 6]);
        return p_perm(s);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[26:0], v[27]};
            2'd2:    return {v[25:0], v[27:26]};
            default: return v;
        endcase
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[0], v[27:1]};
            2'd2:    return {v[1:0], v[27:2]};
            default: return v;
        endcase
    endfunction

    // Decrypt walks the schedule backwards: round 1 reuses C16/D16 (= C0/D0) unrotated.
    function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dec);
        if (dec && rnd == 5'd1) return 2'd0;
        if (rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16) return 2'd1;
        return 2'd2;
    endfunction

    state_e      state_q;
    logic [4:0]  rnd_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic        out_valid_q;
    logic [63:0] out_block_q;
    logic        dec;

`ifdef DES_DECRYPT_EN
    logic dec_q;
    assign dec = dec_q;
`else
    assign dec = 1'b0;
`endif

    logic [1:0]  shift;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] f_out;

    always_comb begin
        shift = shift_amt(rnd_q, dec);
        if (dec) begin
            c_rot = rotr(c_q, shift);
            d_rot = rotr(d_q, shift);
        end else begin
            c_rot = rotl(c_q, shift);
            d_rot = rotl(d_q, shift);
        end
        subkey = pc2_perm({c_rot, d_rot});
        f_out  = feistel(r_q, subkey);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rnd_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
`ifdef DES_DECRYPT_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        {l_q, r_q} <= ip_perm(bus.in_block);
                        {c_q, d_q} <= pc1_perm(bus.in_key);
                        rnd_q      <= 5'd1;
                        state_q    <= StRound;
`ifdef DES_DECRYPT_EN
                        dec_q      <= bus.in_decrypt;
`endif
                    end
                end
                StRound: begin
                    c_q <= c_rot;
                    d_q <= d_rot;
                    l_q <= r_q;
                    r_q <= l_q ^ f_out;
                    if (rnd_q == 5'd16) begin
                        // Final swap undone: preoutput is R16,L16.
                        out_block_q <= fp_perm({l_q ^ f_out, r_q});
                        out_valid_q <= 1'b1;
                        rnd_q       <= '0;
                        state_q     <= StDone;
                    end else begin
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;
endmodule

// File: tb/tb_des_iter_core.sv
// Directed-vector bench for des_iter_core using published DES known-answer vectors.
module tb_des_iter_core;
    logic clk = 1'b0;
    logic rst;

    des_iter_if bus ();

    des_iter_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2  = 64'h8787878787878787;
    localparam logic [63:0] CT2  = 64'h0000000000000000;

    // Offers one block when in_ready, returns the result and cycles from accept to out_valid.
    task automatic send_block(input logic [63:0] key, input logic [63:0] blk,
                              output logic [63:0] got, output int lat);
        int w = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        bus.in_key   = key;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = bus.out_block;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_block  = '0;
        bus.in_key    = '0;
`ifdef DES_DECRYPT_EN
        bus.in_decrypt = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.out_block !== 64'h0) $display("FAIL rst_out_block: got %h expected 0", bus.out_block);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_encrypt();
        logic [63:0] got;
        int          lat;
        bus.out_ready = 1'b1;
        send_block(KEY1, PT1, got, lat);
        n_checks++;
        if (got !== CT1) $display("FAIL enc1_out: got %h expected %h", got, CT1);
        else n_pass++;
        n_checks++;
        if (lat !== 16) $display("FAIL enc1_latency: got %0d expected 16", lat);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL enc1_release: got valid/ready %b%b expected 01", bus.out_valid,
                     bus.in_ready);
        else n_pass++;
        send_block(KEY2, PT2, got, lat);
        n_checks++;
        if (got !== CT2) $display("FAIL enc2_out: got %h expected %h", got, CT2);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [63:0] got;
        int          lat;
        bus.out_ready = 1'b0;
        send_block(KEY1, PT1, got, lat);
        n_checks++;
        if (lat !== 16) $display("FAIL bp_latency: got %0d expected 16", lat);
        else n_pass++;
        // A competing block is offered while stalled; it must be ignored.
        bus.in_valid = 1'b1;
        bus.in_block = PT2;
        bus.in_key   = KEY2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_block} !== {1'b1, 1'b0, CT1})
                $display("FAIL bp_hold_%0d: got valid %b ready %b out %h expected 1 0 %h", i,
                         bus.out_valid, bus.in_ready, bus.out_block, CT1);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_block} !== {1'b0, 1'b1, CT1})
            $display("FAIL bp_release: got valid %b ready %b out %h expected 0 1 %h",
                     bus.out_valid, bus.in_ready, bus.out_block, CT1);
        else n_pass++;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_no_accept: got in_ready %b expected 1",
                                            bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [63:0] got;
        int          lat;
        logic        seen = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_block  = PT1;
        bus.in_key    = KEY1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_block} !== {1'b0, 64'h0})
            $display("FAIL midrst_state: got valid %b out %h expected 0 0", bus.out_valid,
                     bus.out_block);
        else n_pass++;
        repeat (24) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midrst_no_output: got out_valid seen %b expected 0",
                                    seen);
        else n_pass++;
        send_block(KEY1, PT1, got, lat);
        n_checks++;
        if (got !== CT1) $display("FAIL midrst_rerun: got %h expected %h", got, CT1);
        else n_pass++;
        @(negedge clk);
    endtask

`ifdef DES_DECRYPT_EN
    task automatic test_decrypt();
        logic [63:0] got;
        int          lat;
        bus.out_ready  = 1'b1;
        bus.in_decrypt = 1'b1;
        send_block(KEY1, CT1, got, lat);
        bus.in_decrypt = 1'b0;
        n_checks++;
        if (got !== PT1) $display("FAIL dec_out: got %h expected %h", got, PT1);
        else n_pass++;
        n_checks++;
        if (lat !== 16) $display("FAIL dec_latency: got %0d expected 16", lat);
        else n_pass++;
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back();
        logic [63:0] keys [4] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF,
                                  64'h0101010101010101, 64'h0000000000000000};
        logic [63:0] pts  [4] = '{64'h4E6F772069732074, 64'h68652074696D6520,
                                  64'h8000000000000000, 64'h0000000000000000};
        logic [63:0] exps [4] = '{64'h3FA40E8A984D4815, 64'h6A271787AB8883F9,
                                  64'h95F8A5E5DD31D900, 64'h8CA64DE9C1B123A7};
        int acc [4] = '{0, 0, 0, 0};
        int n_acc = 0;
        int n_out = 0;
        int cyc   = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_key   = keys[0];
        bus.in_block = pts[0];
        while (n_out < 4 && cyc < 200) begin
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (bus.out_block !== exps[n_out])
                    $display("FAIL b2b_out_%0d: got %h expected %h", n_out, bus.out_block,
                             exps[n_out]);
                else n_pass++;
                n_out++;
            end
            if (n_acc < 4 && bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
                acc[n_acc] = cyc;
                n_acc++;
            end else if (n_acc < 4) begin
                bus.in_key   = keys[n_acc];
                bus.in_block = pts[n_acc];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (n_out !== 4) $display("FAIL b2b_count: got %0d results expected 4", n_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (acc[i + 1] - acc[i] !== 18)
                $display("FAIL b2b_spacing_%0d: got %0d cycles expected 18", i,
                         acc[i + 1] - acc[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_backpressure();
        test_reset_midop();
`ifdef DES_DECRYPT_EN
        test_decrypt();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
